// File: rtl/ex_muldiv_unit_if.sv
// rtl/ex_muldiv_unit_if.sv - request/response bundle between EX control and the mul/div unit
interface ex_muldiv_unit_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [3:0]       func;
  logic [WIDTH-1:0] data1;
  logic [WIDTH-1:0] data2;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] resultLo;
  logic [WIDTH-1:0] resultHi;
  logic             divZero;

  modport master (
    output start, func, data1, data2, flush,
    input  busy, done, resultLo, resultHi, divZero
  );

  modport slave (
    input  start, func, data1, data2, flush,
    output busy, done, resultLo, resultHi, divZero
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative signed 16x16 multiply / restoring divide for the EX stage
module ex_muldiv_unit #(
  parameter int         WIDTH    = 16,
  parameter logic [3:0] MUL_FUNC = 4'b0100,
  parameter logic [3:0] DIV_FUNC = 4'b0101
) (
  input logic              clk,
  input logic              rstN,
  ex_muldiv_unit_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t             state, state_nxt;
  logic [3:0]         cnt, cnt_nxt;
  logic [WIDTH-1:0]   a_mag, a_mag_nxt, b_mag, b_mag_nxt;
  logic               neg_res, neg_res_nxt, neg_rem, neg_rem_nxt;
  // MUL: running product. DIV: {remainder, dividend/quotient shift register}.
  logic [2*WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH-1:0]   res_lo, res_lo_nxt, res_hi, res_hi_nxt;
  logic               div_zero, div_zero_nxt;

  logic               accept;
  logic [2*WIDTH-1:0] mul_acc;
  logic [WIDTH:0]     rem_sh;
  logic               ge;
  logic [WIDTH-1:0]   rem_new;
  logic [2*WIDTH-1:0] div_acc;
  logic [WIDTH-1:0]   d1_abs, d2_abs;

  assign bus.busy     = (state == MUL) || (state == DIV);
  assign bus.done     = (state == DONE);
  assign bus.resultLo = res_lo;
  assign bus.resultHi = res_hi;
  assign bus.divZero  = div_zero;

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state    <= IDLE;
      cnt      <= '0;
      a_mag    <= '0;
      b_mag    <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      acc      <= '0;
      res_lo   <= '0;
      res_hi   <= '0;
      div_zero <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      a_mag    <= a_mag_nxt;
      b_mag    <= b_mag_nxt;
      neg_res  <= neg_res_nxt;
      neg_rem  <= neg_rem_nxt;
      acc      <= acc_nxt;
      res_lo   <= res_lo_nxt;
      res_hi   <= res_hi_nxt;
      div_zero <= div_zero_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    a_mag_nxt    = a_mag;
    b_mag_nxt    = b_mag;
    neg_res_nxt  = neg_res;
    neg_rem_nxt  = neg_rem;
    acc_nxt      = acc;
    res_lo_nxt   = res_lo;
    res_hi_nxt   = res_hi;
    div_zero_nxt = div_zero;

    accept = bus.start && ((bus.func == MUL_FUNC) || (bus.func == DIV_FUNC))
             && ((state == IDLE) || (state == DONE));
    d1_abs = bus.data1[WIDTH-1] ? -bus.data1 : bus.data1;
    d2_abs = bus.data2[WIDTH-1] ? -bus.data2 : bus.data2;

    mul_acc = acc + (b_mag[cnt] ? ({{WIDTH{1'b0}}, a_mag} << cnt) : '0);

    rem_sh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    ge      = rem_sh >= {1'b0, b_mag};
    rem_new = ge ? WIDTH'(rem_sh - {1'b0, b_mag}) : rem_sh[WIDTH-1:0];
    div_acc = {rem_new, acc[WIDTH-2:0], ge};

    case (state)
      IDLE, DONE: begin
        state_nxt = IDLE;
        if (accept) begin
          div_zero_nxt = 1'b0;
          cnt_nxt      = '0;
          a_mag_nxt    = d1_abs;
          b_mag_nxt    = d2_abs;
          neg_res_nxt  = bus.data1[WIDTH-1] ^ bus.data2[WIDTH-1];
          neg_rem_nxt  = bus.data1[WIDTH-1];
          if (bus.func == MUL_FUNC) begin
            acc_nxt   = '0;
            state_nxt = MUL;
          end else if (bus.data2 == '0) begin
            res_lo_nxt   = '1;
            res_hi_nxt   = bus.data1;
            div_zero_nxt = 1'b1;
            state_nxt    = DONE;
          end else begin
            acc_nxt   = {{WIDTH{1'b0}}, d1_abs};
            state_nxt = DIV;
          end
        end
      end
      MUL: begin
        acc_nxt = mul_acc;
        cnt_nxt = cnt + 4'd1;
        if (cnt == 4'd15) begin
          {res_hi_nxt, res_lo_nxt} = neg_res ? -mul_acc : mul_acc;
          state_nxt = DONE;
        end
      end
      DIV: begin
        acc_nxt = div_acc;
        cnt_nxt = cnt + 4'd1;
        if (cnt == 4'd15) begin
          res_lo_nxt = neg_res ? -div_acc[WIDTH-1:0] : div_acc[WIDTH-1:0];
          res_hi_nxt = neg_rem ? -div_acc[2*WIDTH-1:WIDTH] : div_acc[2*WIDTH-1:WIDTH];
          state_nxt  = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Flush wins over acceptance and iteration; visible results are left untouched.
    if (bus.flush) begin
      state_nxt    = IDLE;
      res_lo_nxt   = res_lo;
      res_hi_nxt   = res_hi;
      div_zero_nxt = div_zero;
    end
  end
endmodule
